// File: rtl/pulse_cmd_pkg.sv
// Shared constants for the pulse command path.
// Used by the command arbiter and pulse_gen.
package pulse_cmd_pkg;

    localparam int CMD_W      = 32;
    localparam int OP_MSB     = 31;
    localparam int OP_LSB     = 24;
    localparam int COARSE_MSB = 23;
    localparam int COARSE_LSB = 8;
    localparam int FINE_MSB   = 7;
    localparam int FINE_LSB   = 0;

    localparam logic [7:0] OP_RESET_CLOCK = 8'd0;
    localparam logic [7:0] OP_SEND_PULSE  = 8'd1;
    localparam logic [7:0] OP_SET_PERIOD  = 8'd2;

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } arb_state_t;

    function automatic logic op_legal(input logic [CMD_W-1:0] word);
        return word[OP_MSB:OP_LSB] <= OP_SET_PERIOD;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Rotating-base priority pick: first set request at or after base.
// Index wraps modulo NUM_REQ.
module rr_select #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         base,
    output logic [2:0]         index,
    output logic               any
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [3:0]           off;
    logic [3:0]           sum;

    // Rotate by base via a doubled vector, then take the lowest set bit.
    always_comb begin
        dbl = {req, req};
        rot = NUM_REQ'(dbl >> base);
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = 4'(k);
        end
        sum = 4'(base) + off;
        if (sum >= 4'(NUM_REQ)) sum = sum - 4'(NUM_REQ);
        index = sum[2:0];
        any   = |req;
    end

endmodule

// File: rtl/pulse_cmd_arbiter.sv
// Burst-locking round-robin arbiter feeding the pulse command FIFO.
// Drops illegal opcodes and force-releases stalled bursts.
module pulse_cmd_arbiter
    import pulse_cmd_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [CMD_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_write,
    output logic [CMD_W-1:0]         fifo_data,
    output logic [2:0]               grant_id,
    output logic                     busy,
    output logic                     illegal_cmd,
    output logic                     timeout_err
);

    arb_state_t state, state_n;

    logic [2:0]         gid, gid_n, gid_inc;
    logic [2:0]         rr_ptr, rr_n;
    logic [15:0]        cnt, cnt_n;
    logic               ill_n, tmo_n;
    logic [NUM_REQ-1:0] sel;
    logic [CMD_W-1:0]   word;
    logic               gv, gl, legal, xfer, tmo_hit;
    logic [2:0]         pick;
    logic               pick_any;

    rr_select #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_select (
        .req  (req_valid),
        .base (rr_ptr),
        .index(pick),
        .any  (pick_any)
    );

    always_comb begin
        sel  = '0;
        word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel[i] = (gid == 3'(i));
            if (sel[i]) word = req_data[CMD_W*i +: CMD_W];
        end
        gv      = |(req_valid & sel);
        gl      = |(req_last & sel);
        legal   = op_legal(word);
        gid_inc = (gid == 3'(NUM_REQ - 1)) ? 3'd0 : gid + 3'd1;
    end

    assign busy     = (state == ST_LOCK);
    assign grant_id = busy ? gid : 3'd0;
    assign xfer     = busy && gv && !fifo_full;
    // A full FIFO freezes the idle count as well as the transfer.
    assign tmo_hit  = busy && !gv && !fifo_full &&
                      (17'(cnt) + 17'd1 >= 17'(TIMEOUT));

    assign req_ready  = (busy && !fifo_full && !rst) ? sel : '0;
    assign fifo_write = xfer && legal && !rst;
    assign fifo_data  = fifo_write ? word : '0;

    always_comb begin
        state_n = state;
        gid_n   = gid;
        rr_n    = rr_ptr;
        cnt_n   = cnt;
        ill_n   = 1'b0;
        tmo_n   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_n = ST_LOCK;
                    gid_n   = pick;
                    cnt_n   = '0;
                end
            end
            ST_LOCK: begin
                ill_n = xfer && !legal;
                if (xfer) begin
                    cnt_n = '0;
                    if (gl) begin
                        state_n = ST_IDLE;
                        rr_n    = gid_inc;
                    end
                end else if (tmo_hit) begin
                    state_n = ST_IDLE;
                    rr_n    = gid_inc;
                    cnt_n   = '0;
                    tmo_n   = 1'b1;
                end else if (!gv && !fifo_full) begin
                    cnt_n = cnt + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            gid         <= '0;
            rr_ptr      <= '0;
            cnt         <= '0;
            illegal_cmd <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            gid         <= gid_n;
            rr_ptr      <= rr_n;
            cnt         <= cnt_n;
            illegal_cmd <= ill_n;
            timeout_err <= tmo_n;
        end
    end

endmodule

// File: tb/tb_pulse_cmd_arbiter.sv
// Bench for pulse_cmd_arbiter: vector table, directed corners,
// and random traffic against a behavioural model.
module tb_pulse_cmd_arbiter;

    localparam int N   = 4;
    localparam int TMO = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [32*N-1:0]  req_data = '0;
    logic [N-1:0]     req_last = '0;
    logic [N-1:0]     req_ready;
    logic             fifo_full = 1'b0;
    logic             fifo_write;
    logic [31:0]      fifo_data;
    logic [2:0]       grant_id;
    logic             busy;
    logic             illegal_cmd;
    logic             timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pulse_cmd_arbiter #(
        .NUM_REQ(N),
        .TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_write (fifo_write),
        .fifo_data  (fifo_data),
        .grant_id   (grant_id),
        .busy       (busy),
        .illegal_cmd(illegal_cmd),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic [3:0]  v;
        logic [31:0] w;
        logic        l;
        logic        f;
        logic [3:0]  er;
        logic        ew;
        logic [31:0] ed;
        logic [2:0]  eg;
        logic        eb;
    } vec_t;

    function automatic logic [42:0] pk(input logic [3:0] rdy, input logic wr,
                                       input logic [31:0] d, input logic [2:0] g,
                                       input logic b, input logic il, input logic to);
        return {rdy, wr, d, g, b, il, to};
    endfunction

    task automatic check(input string name, input logic [42:0] exp);
        logic [42:0] act;
        act = pk(req_ready, fifo_write, fifo_data, grant_id, busy,
                 illegal_cmd, timeout_err);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got rdy=%b wr=%b d=%h g=%0d b=%b il=%b to=%b want rdy=%b wr=%b d=%h g=%0d b=%b il=%b to=%b",
                     name, $time, act[42:39], act[38], act[37:6], act[5:3],
                     act[2], act[1], act[0], exp[42:39], exp[38], exp[37:6],
                     exp[5:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] w,
                         input logic l, input logic f, input logic r);
        req_valid = v;
        req_data  = {N{w}};
        req_last  = {N{l}};
        fifo_full = f;
        rst       = r;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(4'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(4'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("reset", '0);
        tick();
    endtask

    // Behavioural model state
    int          owner;
    int          ptr;
    int          mcnt;
    logic        pill;
    logic        ptmo;

    initial begin
        vec_t        tbl[9];
        logic [3:0]  v;
        logic [3:0]  l;
        logic        f;
        logic        r;
        logic [31:0] words[N];
        logic [31:0] tmp;
        logic [7:0]  op;
        logic        xfer;
        logic        legal;
        logic        found;
        logic [3:0]  er;
        logic        ew;
        logic [31:0] ed;
        int          ex;

        tbl[0] = '{4'b0001, 32'h01000A05, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,        3'd0, 1'b0};
        tbl[1] = '{4'b0001, 32'h01000A05, 1'b0, 1'b0, 4'b0001, 1'b1, 32'h01000A05, 3'd0, 1'b1};
        tbl[2] = '{4'b0001, 32'h01000B00, 1'b0, 1'b0, 4'b0001, 1'b1, 32'h01000B00, 3'd0, 1'b1};
        tbl[3] = '{4'b0001, 32'h00000000, 1'b1, 1'b0, 4'b0001, 1'b1, 32'h00000000, 3'd0, 1'b1};
        tbl[4] = '{4'b1001, 32'h01000001, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,        3'd0, 1'b0};
        tbl[5] = '{4'b1001, 32'h01000001, 1'b1, 1'b0, 4'b1000, 1'b1, 32'h01000001, 3'd3, 1'b1};
        tbl[6] = '{4'b0000, 32'h00000000, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,        3'd0, 1'b0};
        tbl[7] = '{4'b1001, 32'h01000002, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,        3'd0, 1'b0};
        tbl[8] = '{4'b1001, 32'h01000002, 1'b1, 1'b0, 4'b0001, 1'b1, 32'h01000002, 3'd0, 1'b1};

        do_reset();

        // Three-word burst, then rr_ptr=1 makes req3 win over req0
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v, tbl[i].w, tbl[i].l, tbl[i].f, 1'b0);
            check($sformatf("vec%0d", i),
                  pk(tbl[i].er, tbl[i].ew, tbl[i].ed, tbl[i].eg, tbl[i].eb,
                     1'b0, 1'b0));
            tick();
        end

        // Round-robin order with all requesters valid
        do_reset();
        for (int g = 0; g < 5; g++) begin
            ex = g % N;
            drive(4'b1111, 32'h01000000 | g, 1'b1, 1'b0, 1'b0);
            check("rr_idle", '0);
            tick();
            drive(4'b1111, 32'h01000000 | g, 1'b1, 1'b0, 1'b0);
            check("rr_grant", pk(4'(1 << ex), 1'b1, 32'h01000000 | g,
                                 3'(ex), 1'b1, 1'b0, 1'b0));
            tick();
        end

        // Illegal opcode is consumed and flagged
        do_reset();
        drive(4'b0100, 32'h07001234, 1'b1, 1'b0, 1'b0);
        check("ill_idle", '0);
        tick();
        drive(4'b0100, 32'h07001234, 1'b1, 1'b0, 1'b0);
        check("ill_xfer", pk(4'b0100, 1'b0, 32'h0, 3'd2, 1'b1, 1'b0, 1'b0));
        tick();
        drive(4'b0000, 32'h0, 1'b0, 1'b0, 1'b0);
        check("ill_pulse", pk(4'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0));
        tick();
        drive(4'b0000, 32'h0, 1'b0, 1'b0, 1'b0);
        check("ill_clear", '0);
        tick();

        // Timeout after four idle cycles, then req2 granted
        do_reset();
        drive(4'b0010, 32'h01000001, 1'b0, 1'b0, 1'b0);
        check("to_idle", '0);
        tick();
        drive(4'b0010, 32'h01000001, 1'b0, 1'b0, 1'b0);
        check("to_first", pk(4'b0010, 1'b1, 32'h01000001, 3'd1, 1'b1, 1'b0, 1'b0));
        tick();
        for (int k = 0; k < TMO; k++) begin
            drive(4'b0100, 32'h01000002, 1'b1, 1'b0, 1'b0);
            check("to_wait", pk(4'b0010, 1'b0, 32'h0, 3'd1, 1'b1, 1'b0, 1'b0));
            tick();
        end
        drive(4'b0100, 32'h01000002, 1'b1, 1'b0, 1'b0);
        check("to_pulse", pk(4'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1));
        tick();
        drive(4'b0100, 32'h01000002, 1'b1, 1'b0, 1'b0);
        check("to_next", pk(4'b0100, 1'b1, 32'h01000002, 3'd2, 1'b1, 1'b0, 1'b0));
        tick();

        // Five full cycles mid-burst: no write, no timeout
        do_reset();
        drive(4'b0001, 32'h01000003, 1'b0, 1'b0, 1'b0);
        tick();
        drive(4'b0001, 32'h01000003, 1'b0, 1'b0, 1'b0);
        check("full_pre", pk(4'b0001, 1'b1, 32'h01000003, 3'd0, 1'b1, 1'b0, 1'b0));
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(4'b0001, 32'h01000004, 1'b1, 1'b1, 1'b0);
            check("full_stall", pk(4'b0, 1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0));
            tick();
        end
        drive(4'b0001, 32'h01000004, 1'b1, 1'b0, 1'b0);
        check("full_resume", pk(4'b0001, 1'b1, 32'h01000004, 3'd0, 1'b1, 1'b0, 1'b0));
        tick();
        drive(4'b0000, 32'h0, 1'b0, 1'b0, 1'b0);
        check("full_done", '0);
        tick();

        // Reset during an active transfer
        do_reset();
        drive(4'b0001, 32'h01000005, 1'b0, 1'b0, 1'b0);
        tick();
        drive(4'b0001, 32'h01000005, 1'b0, 1'b0, 1'b1);
        check("rst_xfer", pk(4'b0, 1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0));
        tick();
        drive(4'b0000, 32'h0, 1'b0, 1'b0, 1'b0);
        check("rst_after", '0);
        tick();

        // Random traffic against the model
        do_reset();
        owner = -1;
        ptr   = 0;
        mcnt  = 0;
        pill  = 1'b0;
        ptmo  = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            v = 4'($urandom_range(0, 15));
            f = ($urandom_range(0, 4) == 0);
            r = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++) begin
                tmp = $urandom;
                if ($urandom_range(0, 5) == 0) op = 8'($urandom_range(3, 255));
                else op = 8'($urandom_range(0, 2));
                words[i] = {op, tmp[23:0]};
                l[i] = ($urandom_range(0, 2) == 0);
                req_data[32*i +: 32] = words[i];
            end
            req_valid = v;
            req_last  = l;
            fifo_full = f;
            rst       = r;
            @(negedge clk);

            xfer  = (owner >= 0) && v[owner] && !f;
            legal = (owner >= 0) && (words[owner][31:24] <= 8'd2);
            er    = (owner >= 0 && !f && !r) ? 4'(1 << owner) : 4'b0;
            ew    = xfer && legal && !r;
            ed    = ew ? words[owner] : 32'h0;
            check("rand", pk(er, ew, ed, (owner >= 0) ? 3'(owner) : 3'd0,
                             owner >= 0, pill, ptmo));

            if (r) begin
                owner = -1;
                ptr   = 0;
                mcnt  = 0;
                pill  = 1'b0;
                ptmo  = 1'b0;
            end else begin
                pill = xfer && !legal;
                ptmo = 1'b0;
                if (owner < 0) begin
                    found = 1'b0;
                    for (int d = 0; d < N; d++) begin
                        if (!found && v[(ptr + d) % N]) begin
                            owner = (ptr + d) % N;
                            mcnt  = 0;
                            found = 1'b1;
                        end
                    end
                end else if (xfer) begin
                    mcnt = 0;
                    if (l[owner]) begin
                        ptr   = (owner + 1) % N;
                        owner = -1;
                    end
                end else if (!v[owner] && !f) begin
                    mcnt++;
                    if (mcnt >= TMO) begin
                        ptr   = (owner + 1) % N;
                        owner = -1;
                        mcnt  = 0;
                        ptmo  = 1'b1;
                    end
                end
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
